oam_dma_arbiter: RTL and testbench
==================================

// Module: oam_dma_arbiter
// PURPOSE
// Shares the single 16-bit memory bus between the CPU core and an OAM DMA engine.
// A CPU write to FF46 starts a copy of DMA_LEN bytes from {src_hi,8'h00} to FE00, one byte per M-cycle.
// Sits between the CPU bus interface and the memory model/MMU.
// The arbiter takes CPU T-cycle phase from the decoder's t_cycle.
// PARAMETERS
// ADDR_SIZE    16    bus address width
// DATA_SIZE    8     bus data width
// DMA_LEN      160   bytes per transfer (1..256)
// START_DELAY  1     idle M-cycles between the FF46 write M-cycle and the first transfer
// PORTS
// clk          in   1   system clock
// rst          in   1   synchronous reset, active-low
// t_cycle      in   2   CPU T-cycle phase 0..3; an M-cycle ends on an edge where t_cycle==3
// cpu_addr     in   16  CPU address
// cpu_wr_data  in   8   CPU write data
// cpu_rd       in   1   CPU read strobe
// cpu_wr       in   1   CPU write strobe (one clk, memory commits on that edge)
// cpu_rd_data  out  8   read data to CPU
// mem_addr     out  16  granted address to memory
// mem_wr_data  out  8   granted write data
// mem_rd       out  1   granted read strobe
// mem_wr       out  1   granted write strobe
// mem_rd_data  in   8   memory read data, valid combinationally with mem_rd
// dma_active   out  1   high while in XFER
// dma_src_hi   out  8   FF46 register (readback value)
// BEHAVIOUR
// - Reset (rst==0 at clk edge): state=IDLE, idx=0, dma_src_hi=8'h00, byte buffer=8'h00, dma_active=0.
//   Bus is fully passed to the CPU while reset is held. Reset mid-transfer aborts with no further writes.
// - FF46 write: cpu_wr && cpu_addr==16'hFF46 latches cpu_wr_data into dma_src_hi, sets idx=0, state=ARM.
//   The write is always accepted (in any state); during XFER it restarts the transfer at idx 0.
//   FF46 writes are not forwarded to mem_wr. FF46 reads return dma_src_hi.
// - ARM: waits for the M-cycle end of the write M-cycle, then START_DELAY more M-cycles, then enters XFER
//   at t_cycle==0.
// - XFER, one byte per M-cycle. Source=={src_hi,idx}; dest=={8'hFE,idx}; high byte is used verbatim.
//   t0: mem_rd=1, mem_addr=source.
//   t1: buffer<=mem_rd_data.
//   t2: mem_wr=1, mem_addr=dest, mem_wr_data=buffer.
//   t3: idx<=idx+1. If idx==DMA_LEN-1, state<=IDLE and dma_active falls on that edge.
//   idx is 8 bits wide and never wraps past DMA_LEN-1.
// - Transfer timing: XFER lasts exactly DMA_LEN M-cycles. With default parameters that is 160 M-cycles,
//   i.e. 640 clk.
// - IDLE/ARM: mem_* = cpu_* combinationally; cpu_rd_data=mem_rd_data (except FF46).
// - HRAM: CPU accesses to FF80..FFFE are always passed through.
//   HRAM and FF46 never conflict with DMA in any configuration.
// - cpu_rd_data is only meaningful while cpu_rd is high. When neither side drives the bus,
//   mem_rd=mem_wr=0 and mem_addr=0.
// CONFIGURATION
// - Macro: DMA_BUS_LOCK_EN.
// - Defined: during XFER the DMA owns the bus. CPU reads outside HRAM/FF46 return 8'hFF.
//   CPU writes outside HRAM/FF46 are dropped (no mem_wr).
// - Undefined (cycle steal): CPU has priority.
//   If the CPU asserts cpu_rd or cpu_wr outside HRAM/FF46 at any time during an XFER M-cycle,
//   the CPU access is passed through.
//   The DMA byte for that M-cycle is skipped (buffer not written, idx held), so the transfer stretches
//   by one M-cycle. The DMA retries the same idx next M-cycle.
//   Conflict is evaluated per M-cycle from t0 onward. A CPU strobe first seen at t2 suppresses the DMA
//   write and holds idx.
// TESTING
// - Copy: preload C000..C09F=idx^8'h5A, write 8'hC0 to FF46.
//   -> FE00..FE9F match the source; dma_active is high for exactly 640 clk; dma_src_hi==8'hC0.
// - Start latency: FF46 write in M-cycle n -> first mem_rd at C000 at t0 of M-cycle n+1+START_DELAY.
//   With default parameters that is n+2.
// - Bus lock (macro defined): CPU reads 8000 mid-DMA -> 8'hFF. CPU writes FF85 <- 8'h3C -> HRAM updated.
//   CPU writes 8000 <- 8'h11 -> memory unchanged.
// - Cycle steal (macro undefined): CPU reads D000 in 3 separate M-cycles during DMA.
//   -> the reads return memory data; dma_active lasts 163 M-cycles; FE00..FE9F are still correct.
// - Restart: write 8'hC0 to FF46, then after 50 bytes write 8'hD0 to FF46.
//   -> idx restarts at 0; FE00..FE9F==D000..D09F at completion.
// - Reset mid-DMA: pull rst low at idx==80 for 1 clk.
//   -> next edge IDLE, dma_active=0, dma_src_hi=0; no mem_wr to FExx afterwards.
//   FE50..FE9F hold their pre-DMA values.

Source files
------------

// File: rtl/oam_dma_arbiter_if.sv
// oam_dma_arbiter_if: CPU-side and memory-side bus bundle shared through the OAM DMA arbiter
// slave  : arbiter side (takes CPU request and memory read data, drives memory request and CPU read data)
// master : environment side (CPU core plus memory model)
interface oam_dma_arbiter_if #(
  parameter int ADDR_SIZE = 16,
  parameter int DATA_SIZE = 8
);
  logic [ADDR_SIZE-1:0] cpu_addr;
  logic [DATA_SIZE-1:0] cpu_wr_data;
  logic                 cpu_rd;
  logic                 cpu_wr;
  logic [DATA_SIZE-1:0] cpu_rd_data;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [DATA_SIZE-1:0] mem_wr_data;
  logic                 mem_rd;
  logic                 mem_wr;
  logic [DATA_SIZE-1:0] mem_rd_data;
  modport slave (
    input  cpu_addr, cpu_wr_data, cpu_rd, cpu_wr, mem_rd_data,
    output cpu_rd_data, mem_addr, mem_wr_data, mem_rd, mem_wr
  );
  modport master (
    output cpu_addr, cpu_wr_data, cpu_rd, cpu_wr, mem_rd_data,
    input  cpu_rd_data, mem_addr, mem_wr_data, mem_rd, mem_wr
  );
endinterface

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: shares one memory bus between the CPU and the OAM DMA engine (FF46 -> FE00 copy)
// clk, rst (sync, active-low), t_cycle (CPU T-cycle phase, M-cycle ends at 3)
// bus (slave): cpu_addr/cpu_wr_data/cpu_rd/cpu_wr/cpu_rd_data and mem_addr/mem_wr_data/mem_rd/mem_wr/mem_rd_data
// dma_active: high while transferring; dma_src_hi: FF46 source page register
// DMA_BUS_LOCK_EN: defined -> DMA owns the bus during a transfer; undefined -> CPU steals M-cycles
module oam_dma_arbiter #(
  parameter int ADDR_SIZE   = 16,
  parameter int DATA_SIZE   = 8,
  parameter int DMA_LEN     = 160,
  parameter int START_DELAY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        t_cycle,
  oam_dma_arbiter_if.slave  bus,
  output logic              dma_active,
  output logic [7:0]        dma_src_hi
);
  localparam int CW = $clog2(START_DELAY + 2);
  typedef enum logic [1:0] {IDLE, ARM, XFER} state_t;
  state_t state, state_n;
  logic [7:0] idx;
  logic [DATA_SIZE-1:0] buffer;
  logic [CW-1:0] arm_cnt;
  logic m_end, reg_hit, hram, cpu_req, cpu_bus, wr_reg, xfer, last, steal, blocked, cpu_en, dma_rd, dma_wr;
  assign m_end = t_cycle == 2'd3;
  assign reg_hit = bus.cpu_addr == ADDR_SIZE'(16'hFF46);
  assign hram = bus.cpu_addr >= ADDR_SIZE'(16'hFF80) && bus.cpu_addr <= ADDR_SIZE'(16'hFFFE);
  assign cpu_req = bus.cpu_rd || bus.cpu_wr;
  assign cpu_bus = cpu_req && !reg_hit && !hram;
  assign wr_reg = bus.cpu_wr && reg_hit;
  assign xfer = rst && state == XFER;
  assign last = idx == 8'(DMA_LEN - 1);
`ifdef DMA_BUS_LOCK_EN
  assign steal = 1'b0;
  assign blocked = xfer && cpu_bus;
`else
  // steal_q remembers a CPU bus access seen earlier in the current XFER M-cycle
  logic steal_q;
  assign steal = xfer && (steal_q || cpu_bus);
  assign blocked = 1'b0;
  always_ff @(posedge clk) steal_q <= rst && !wr_reg && !m_end && steal;
`endif
  assign cpu_en = cpu_req && !blocked;
  assign dma_rd = xfer && !steal && t_cycle == 2'd0;
  assign dma_wr = xfer && !steal && t_cycle == 2'd2;
  always_ff @(posedge clk) state <= rst ? state_n : IDLE;
  // a write on the closing edge of its M-cycle already counts that M-cycle as ended
  always_comb begin
    state_n = wr_reg ? ((m_end && START_DELAY == 0) ? XFER : ARM)
            : (state == ARM && m_end && arm_cnt == CW'(START_DELAY)) ? XFER
            : (state == XFER && m_end && !steal && last) ? IDLE
            : state;
  end
  // the source byte is captured on the t0 edge, while the combinational read data is live
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx <= '0;
      dma_src_hi <= '0;
      buffer <= '0;
      arm_cnt <= '0;
    end else begin
      dma_src_hi <= wr_reg ? 8'(bus.cpu_wr_data) : dma_src_hi;
      idx <= wr_reg ? '0 : (xfer && m_end && !steal && !last) ? idx + 8'd1 : idx;
      arm_cnt <= wr_reg ? CW'(m_end) : (state == ARM && m_end) ? arm_cnt + 1'b1 : arm_cnt;
      buffer <= dma_rd ? bus.mem_rd_data : buffer;
    end
  end
  always_comb begin
    dma_active = state == XFER;
    bus.mem_addr = cpu_en ? bus.cpu_addr
                 : dma_rd ? ADDR_SIZE'({dma_src_hi, idx})
                 : dma_wr ? ADDR_SIZE'({8'hFE, idx})
                 : '0;
    bus.mem_rd = cpu_en ? bus.cpu_rd : dma_rd;
    bus.mem_wr = cpu_en ? (bus.cpu_wr && !reg_hit) : dma_wr;
    bus.mem_wr_data = cpu_en ? bus.cpu_wr_data : dma_wr ? buffer : '0;
    bus.cpu_rd_data = reg_hit ? DATA_SIZE'(dma_src_hi) : blocked ? '1 : bus.mem_rd_data;
  end
endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb_oam_dma_arbiter: vector table, directed DMA sequences and randomized CPU traffic against a transfer-level model
module tb_oam_dma_arbiter;
  localparam int DMA_LEN = 160;
  localparam int START_DELAY = 1;
`ifdef DMA_BUS_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] t_cycle = 2'd0;
  logic dma_active;
  logic [7:0] dma_src_hi;
  oam_dma_arbiter_if bus ();
  oam_dma_arbiter #(.DMA_LEN(DMA_LEN), .START_DELAY(START_DELAY)) dut (
    .clk(clk), .rst(rst), .t_cycle(t_cycle), .bus(bus.slave),
    .dma_active(dma_active), .dma_src_hi(dma_src_hi)
  );
  logic [7:0] mem [0:65535];
  assign bus.mem_rd_data = bus.mem_rd ? mem[bus.mem_addr] : 8'h00;
  always #5 clk = ~clk;
  int total = 0, bad = 0, clk_n = 0, act_clks = 0, first_rd_clk = -1, fe_wr = 0;
  logic [15:0] first_rd_addr = '0;
  logic [7:0] rd_s;
  typedef struct {logic rd; logic wr; logic [15:0] a; logic [7:0] d;
                  logic e_rd; logic e_wr; logic [15:0] e_a; logic [7:0] e_wd; logic [7:0] e_rdata;} vec_t;
  typedef struct {bit [1:0] op; bit [1:0] ph; logic [7:0] lo; logic [7:0] d;} acc_t;
  vec_t vecs [7];
  acc_t plan [0:511];
  logic [7:0] ref8 [0:255];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    logic w;
    logic [15:0] wa;
    logic [7:0] wd;
    @(negedge clk);
    rd_s = bus.cpu_rd_data;
    w = bus.mem_wr;
    wa = bus.mem_addr;
    wd = bus.mem_wr_data;
    if (dma_active) act_clks++;
    if (dma_active && bus.mem_rd && first_rd_clk < 0) begin
      first_rd_clk = clk_n;
      first_rd_addr = bus.mem_addr;
    end
    if (w && wa[15:8] == 8'hFE) fe_wr++;
    @(posedge clk);
    if (w) mem[wa] = wd;
    #1;
    clk_n++;
    t_cycle = t_cycle + 2'd1;
  endtask
  task automatic cpu(logic r, logic w, logic [15:0] a, logic [7:0] d);
    bus.cpu_rd = r;
    bus.cpu_wr = w;
    bus.cpu_addr = a;
    bus.cpu_wr_data = d;
  endtask
  task automatic start_dma(logic [7:0] v, output int exp_clk);
    while (t_cycle != 2'd1) tick();
    exp_clk = (clk_n / 4 + 1 + START_DELAY) * 4;
    first_rd_clk = -1;
    cpu(1'b0, 1'b1, 16'hFF46, v);
    tick();
    cpu(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask
  task automatic wait_done(int budget);
    int k = 0;
    while (!dma_active && k < budget) begin tick(); k++; end
    while (dma_active && k < budget) begin tick(); k++; end
    chk("timeout", 32'(k >= budget), 0);
  endtask
  task automatic check_fe(logic [7:0] hi, string name);
    for (int i = 0; i < DMA_LEN; i++) chk(name, mem[{8'hFE, 8'(i)}], mem[{hi, 8'(i)}]);
  endtask
  task automatic clear_fe(logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[{8'hFE, 8'(i)}] = v;
  endtask
  initial begin
    int e, k, s_r, e_r, rem;
    logic [7:0] hi;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) begin
      mem[{8'hC0, 8'(i)}] = 8'(i) ^ 8'h5A;
      mem[{8'hD0, 8'(i)}] = 8'(i) ^ 8'hA5;
    end
    clear_fe(8'h00);
    mem[16'h1234] = 8'h77;
    mem[16'hFF90] = 8'h4B;
    mem[16'h8000] = 8'h22;
    cpu(1'b1, 1'b0, 16'h1234, 8'h00);
    repeat (3) tick();
    chk("rst_pass_rd", rd_s, 8'h77);
    chk("rst_active", dma_active, 0);
    chk("rst_src_hi", dma_src_hi, 8'h00);
    rst = 1'b1;
    cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    tick();
    vecs[0] = '{1'b1, 1'b0, 16'h1234, 8'h00, 1'b1, 1'b0, 16'h1234, 8'h00, 8'h77};
    vecs[1] = '{1'b0, 1'b1, 16'h9000, 8'h3C, 1'b0, 1'b1, 16'h9000, 8'h3C, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 16'hFF90, 8'h00, 1'b1, 1'b0, 16'hFF90, 8'h00, 8'h4B};
    vecs[3] = '{1'b0, 1'b0, 16'hABCD, 8'h55, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 16'hFF46, 8'h00, 1'b1, 1'b0, 16'hFF46, 8'h00, 8'h00};
    vecs[5] = '{1'b0, 1'b1, 16'hFF46, 8'hC0, 1'b0, 1'b0, 16'hFF46, 8'hC0, 8'h00};
    vecs[6] = '{1'b1, 1'b0, 16'hC005, 8'h00, 1'b1, 1'b0, 16'hC005, 8'h00, 8'h5F};
    foreach (vecs[i]) begin
      cpu(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d);
      #1;
      chk($sformatf("vec%0d_rd", i), bus.mem_rd, vecs[i].e_rd);
      chk($sformatf("vec%0d_wr", i), bus.mem_wr, vecs[i].e_wr);
      chk($sformatf("vec%0d_addr", i), bus.mem_addr, vecs[i].e_a);
      chk($sformatf("vec%0d_wd", i), bus.mem_wr_data, vecs[i].e_wd);
      if (vecs[i].rd) chk($sformatf("vec%0d_rdata", i), bus.cpu_rd_data, vecs[i].e_rdata);
    end
    cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    tick();
    act_clks = 0;
    start_dma(8'hC0, e);
    wait_done(3000);
    chk("copy_lat", first_rd_clk, e);
    chk("copy_lat_addr", first_rd_addr, 16'hC000);
    chk("copy_active", act_clks, 4 * DMA_LEN);
    chk("copy_src_hi", dma_src_hi, 8'hC0);
    check_fe(8'hC0, "copy_fe");
    chk("copy_fe_end", mem[16'hFEA0], 8'h00);
    cpu(1'b1, 1'b0, 16'hFF46, 8'h00);
    #1;
    chk("ff46_read", bus.cpu_rd_data, 8'hC0);
    cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    tick();
    clear_fe(8'h00);
    act_clks = 0;
    start_dma(8'hC0, e);
`ifdef DMA_BUS_LOCK_EN
    repeat (40) tick();
    while (t_cycle != 2'd1) tick();
    cpu(1'b1, 1'b0, 16'h8000, 8'h00);
    tick();
    chk("lock_rd", rd_s, 8'hFF);
    while (t_cycle != 2'd1) tick();
    cpu(1'b0, 1'b1, 16'hFF85, 8'h3C);
    tick();
    while (t_cycle != 2'd1) tick();
    cpu(1'b0, 1'b1, 16'h8000, 8'h11);
    tick();
    cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    wait_done(3000);
    chk("lock_hram", mem[16'hFF85], 8'h3C);
    chk("lock_drop", mem[16'h8000], 8'h22);
    chk("lock_active", act_clks, 4 * DMA_LEN);
    check_fe(8'hC0, "lock_fe");
`else
    for (int n = 0; n < 3; n++) begin
      repeat (40) tick();
      while (t_cycle != 2'd2) tick();
      cpu(1'b1, 1'b0, 16'hD000, 8'h00);
      tick();
      cpu(1'b0, 1'b0, 16'h0000, 8'h00);
      chk("steal_rd", rd_s, 8'hA5);
    end
    wait_done(3000);
    chk("steal_active", act_clks, 4 * (DMA_LEN + 3));
    check_fe(8'hC0, "steal_fe");
`endif
    clear_fe(8'h00);
    fe_wr = 0;
    start_dma(8'hC0, e);
    k = 0;
    while (fe_wr < 50 && k < 2000) begin tick(); k++; end
    chk("restart_50", fe_wr, 50);
    start_dma(8'hD0, e);
    wait_done(3000);
    chk("restart_lat", first_rd_clk, e);
    chk("restart_addr", first_rd_addr, 16'hD000);
    chk("restart_src_hi", dma_src_hi, 8'hD0);
    check_fe(8'hD0, "restart_fe");
    clear_fe(8'hEE);
    fe_wr = 0;
    start_dma(8'hC0, e);
    k = 0;
    while (fe_wr < 80 && k < 2000) begin tick(); k++; end
    chk("reset_80", fe_wr, 80);
    while (t_cycle != 2'd0) tick();
    rst = 1'b0;
    fe_wr = 0;
    tick();
    rst = 1'b1;
    chk("reset_active", dma_active, 0);
    chk("reset_src_hi", dma_src_hi, 8'h00);
    repeat (800) tick();
    chk("reset_no_wr", fe_wr, 0);
    for (int i = 0; i < 80; i++) chk("reset_fe_lo", mem[{8'hFE, 8'(i)}], 8'(i) ^ 8'h5A);
    for (int i = 80; i < DMA_LEN; i++) chk("reset_fe_hi", mem[{8'hFE, 8'(i)}], 8'hEE);
    for (int it = 0; it < 3; it++) begin
      hi = 8'($urandom_range(8'hC0, 8'hCF));
      for (int i = 0; i < 256; i++) begin
        mem[{hi, 8'(i)}] = 8'($urandom);
        ref8[i] = 8'($urandom);
        mem[{8'h80, 8'(i)}] = ref8[i];
      end
      clear_fe(8'h00);
      for (int r = 0; r < 512; r++) begin
        plan[r].op = ($urandom_range(0, 7) < 2) ? 2'($urandom_range(1, 2)) : 2'd0;
        plan[r].ph = 2'($urandom_range(0, 3));
        plan[r].lo = 8'($urandom);
        plan[r].d = 8'($urandom);
      end
      s_r = START_DELAY;
      rem = DMA_LEN;
      e_r = s_r;
      while (rem > 0 && e_r < 500) begin
        if (LOCK || plan[e_r].op == 2'd0) rem--;
        e_r++;
      end
      act_clks = 0;
      start_dma(hi, e);
      while (t_cycle != 2'd0) tick();
      for (int r = 0; r <= e_r + 1; r++) begin
        for (int p = 0; p < 4; p++) begin
          if (plan[r].op != 2'd0 && plan[r].ph == 2'(p)) begin
            cpu(plan[r].op == 2'd1, plan[r].op == 2'd2, {8'h80, plan[r].lo}, plan[r].d);
            tick();
            cpu(1'b0, 1'b0, 16'h0000, 8'h00);
            if (plan[r].op == 2'd1)
              chk("rnd_rd", rd_s, (LOCK && r >= s_r && r < e_r) ? 8'hFF : ref8[plan[r].lo]);
            else if (!(LOCK && r >= s_r && r < e_r))
              ref8[plan[r].lo] = plan[r].d;
          end else tick();
        end
      end
      chk("rnd_active", act_clks, 4 * (e_r - s_r));
      chk("rnd_lat", first_rd_clk, e);
      check_fe(hi, "rnd_fe");
      for (int i = 0; i < 256; i++) chk("rnd_page80", mem[{8'h80, 8'(i)}], ref8[i]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
